// File: rtl/ripple_carry_adder.sv
// Registered unsigned ripple-carry adder: {Cout,S} = A + B + Cin.
// The sum is formed by a chain of 1-bit full-adder cells, each cell's
// carry-out feeding the next cell's carry-in, with no lookahead. The result
// is captured on the rising edge of clk one cycle after valid operands.

// Single-bit full adder; the unit cell of the ripple chain.
module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign s       = a_xor_b ^ c_in;
    assign c_out   = (a & b) | (c_in & a_xor_b);

endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 8  // operand/sum width, legal range 1..32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid
);

    // carry[i] enters cell i; carry[WIDTH] leaves the top cell.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] s_d,         s_q;
    logic             cout_d,      cout_q;
    logic             out_valid_d, out_valid_q;

    assign carry[0] = Cin;

    // Ripple chain: WIDTH cells, carry threaded from LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rca_full_adder u_fa (
            .a     (A[i]),
            .b     (B[i]),
            .c_in  (carry[i]),
            .s     (sum[i]),
            .c_out (carry[i+1])
        );
    end

    // Next-state: capture a new result on in_valid, otherwise hold the sum.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        s_d         = s_q;
        cout_d      = cout_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            s_d         = sum;
            cout_d      = carry[WIDTH];
            out_valid_d = 1'b1;
        end
    end

    // Output registers with synchronous reset taking priority over in_valid.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // values; blocking here would create order-dependent simulation.
        if (rst) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed bench for ripple_carry_adder (WIDTH=8). Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge.

module tb_ripple_carry_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;

    int vectors     = 0;
    int miscompares = 0;

    ripple_carry_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic c);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] exp_sum;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        check("reset_s",    32'(S),         32'h0);
        check("reset_cout", 32'(Cout),      32'h0);
        check("reset_ov",   32'(out_valid), 32'h0);

        // Carry chain
        step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
        check("chain_ff_00_1", 32'({out_valid, Cout, S}), 32'h300);
        step(1'b0, 1'b1, 8'h55, 8'hAA, 1'b1);
        check("chain_55_aa_1", 32'({out_valid, Cout, S}), 32'h300);

        // Extremes
        step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        check("max_sum", 32'({out_valid, Cout, S}), 32'h3FF);
        step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        check("zero_sum", 32'({out_valid, Cout, S}), 32'h200);

        // Hold: S/Cout keep 7/0 while in_valid is low and operands change
        step(1'b0, 1'b1, 8'd3, 8'd4, 1'b0);
        check("hold_load", 32'({out_valid, Cout, S}), 32'h207);
        step(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
        check("hold_1", 32'({out_valid, Cout, S}), 32'h007);
        step(1'b0, 1'b0, 8'h80, 8'h90, 1'b0);
        check("hold_2", 32'({out_valid, Cout, S}), 32'h007);
        step(1'b0, 1'b0, 8'h12, 8'h34, 1'b1);
        check("hold_3", 32'({out_valid, Cout, S}), 32'h007);

        // Reset wins over in_valid; the held 7 must be cleared
        step(1'b1, 1'b1, 8'd200, 8'd100, 1'b0);
        check("rst_vs_valid", 32'({out_valid, Cout, S}), 32'h000);
        step(1'b0, 1'b0, 8'd200, 8'd100, 1'b0);
        check("post_rst_idle", 32'({out_valid, Cout, S}), 32'h000);
        step(1'b0, 1'b1, 8'd200, 8'd100, 1'b0);
        check("post_rst_300", 32'({out_valid, Cout, S}), 32'h200 | 32'd300);

        // Back-to-back results with out_valid high throughout
        step(1'b0, 1'b1, 8'd1, 8'd1, 1'b0);
        check("b2b_2", 32'({out_valid, Cout, S}), 32'h202);
        step(1'b0, 1'b1, 8'd2, 8'd2, 1'b0);
        check("b2b_4", 32'({out_valid, Cout, S}), 32'h204);
        step(1'b0, 1'b1, 8'd3, 8'd3, 1'b0);
        check("b2b_6", 32'({out_valid, Cout, S}), 32'h206);

        // Exhaustive A,B with Cin=0, one operation per cycle
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                step(1'b0, 1'b1, WIDTH'(a), WIDTH'(b), 1'b0);
                exp_sum = 9'(a + b);
                check("exhaustive", 32'({out_valid, Cout, S}), 32'({1'b1, exp_sum}));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
